// File: rtl/sram_like_arbiter_pkg.sv
// Shared types for the sram-like port arbiter: master IDs stored in the in-order ID FIFO.
package sram_like_arbiter_pkg;

    typedef enum logic {
        SRAM_ID_INST = 1'b0,
        SRAM_ID_DATA = 1'b1
    } sram_id_e;

    localparam logic [1:0] INST_SIZE = 2'h2;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of request owners; one entry per accepted request, popped on each response.
module arb_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     push,
    input  logic     pop,
    input  sram_id_e din,
    output logic     full,
    output logic     empty,
    output sram_id_e head
);

    sram_id_e       slots [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    // A response with nothing outstanding is dropped rather than underflowing.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= SRAM_ID_INST;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the inst (fetch) and data (load/store) masters,
// with data priority, a grant lock while a request waits, and in-order response routing.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned OT_DEPTH = 4,
    parameter int unsigned OT_AW    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    sram_id_e sel;
    sram_id_e lock_sel;
    sram_id_e head;
    logic     lock;
    logic     ready;
    logic     accept;
    logic     fifo_full;
    logic     fifo_empty;

    always_comb begin
        if (lock) begin
            sel = lock_sel;
        end else if (data_req) begin
            sel = SRAM_ID_DATA;
        end else begin
            sel = SRAM_ID_INST;
        end
    end

    // ready is cleared asynchronously, so mem_req drops in the same cycle resetn falls.
    assign mem_req = ready && (inst_req || data_req) && !fifo_full;
    assign accept  = mem_req && mem_addr_ok;

    assign inst_addr_ok = accept && (sel == SRAM_ID_INST);
    assign data_addr_ok = accept && (sel == SRAM_ID_DATA);

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = INST_SIZE;
        mem_wstrb = '0;
        mem_addr  = inst_addr;
        mem_wdata = '0;
        if (sel == SRAM_ID_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    // Once presented, a master keeps the port until accepted; a full FIFO leaves the lock alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready    <= 1'b0;
            lock     <= 1'b0;
            lock_sel <= SRAM_ID_INST;
        end else begin
            ready <= 1'b1;
            if (accept) begin
                lock <= 1'b0;
            end else if (mem_req) begin
                lock     <= 1'b1;
                lock_sel <= sel;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH (OT_DEPTH),
        .AW    (OT_AW)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (mem_data_ok),
        .din    (sel),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head)
    );

    assign inst_data_ok = mem_data_ok && !fifo_empty && (head == SRAM_ID_INST);
    assign data_data_ok = mem_data_ok && !fifo_empty && (head == SRAM_ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scenario bench for sram_like_arbiter: owners queued at accept, popped and checked at response.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    bit          exp_q [$];   // 0 = inst owner, 1 = data owner
    bit          exp_own;

    always #5 clk = ~clk;

    sram_like_arbiter #(
        .OT_DEPTH (4),
        .OT_AW    (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    task automatic idle();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'h0;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one accepted request per cycle, alternating I,D,I,D; owners go to the scoreboard.
    task automatic issue_alternating(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            inst_req    = (k % 2 == 0);
            data_req    = (k % 2 == 1);
            inst_addr   = 32'hbfc0_0000 + 4 * k;
            data_addr   = 32'h0000_1000 + 4 * k;
            mem_addr_ok = 1'b1;
            exp_q.push_back(k % 2 == 1);
            next_cycle();
        end
        idle();
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        idle();
        #1;
        resetn      = 1'b0;
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        #2;
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req);
        else pass_cnt++;
        total_cnt++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b00)
            $display("FAIL reset_addr_ok: got %b want 00", {inst_addr_ok, data_addr_ok});
        else pass_cnt++;
        total_cnt++;
        if ({inst_data_ok, data_data_ok} !== 2'b00)
            $display("FAIL reset_data_ok: got %b want 00", {inst_data_ok, data_data_ok});
        else pass_cnt++;
        idle();
        next_cycle();
        resetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_priority();
        inst_req    = 1'b1;
        inst_addr   = 32'hbfc0_0000;
        data_req    = 1'b1;
        data_wr     = 1'b1;
        data_size   = 2'h2;
        data_wstrb  = 4'hf;
        data_addr   = 32'h0000_1000;
        data_wdata  = 32'hdead_beef;
        mem_addr_ok = 1'b1;
        #1;
        total_cnt++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01)
            $display("FAIL prio_data_first: got %b want 01", {inst_addr_ok, data_addr_ok});
        else pass_cnt++;
        total_cnt++;
        if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 32'h0000_1000, 32'hdead_beef})
            $display("FAIL prio_data_mux: got %b %h %h", mem_wr, mem_addr, mem_wdata);
        else pass_cnt++;
        exp_q.push_back(1'b1);
        next_cycle();
        data_req = 1'b0;
        data_wr  = 1'b0;
        #1;
        total_cnt++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10)
            $display("FAIL prio_inst_next: got %b want 10", {inst_addr_ok, data_addr_ok});
        else pass_cnt++;
        total_cnt++;
        if ({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !==
            {1'b0, 2'h2, 4'h0, 32'hbfc0_0000, 32'h0})
            $display("FAIL prio_inst_mux: got %b %h %h %h %h",
                     mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata);
        else pass_cnt++;
        exp_q.push_back(1'b0);
        next_cycle();
        idle();
        for (int unsigned k = 0; k < 2; k++) begin
            mem_data_ok = 1'b1;
            mem_rdata   = 32'h5a00_0000 + k;
            #1;
            exp_own = exp_q.pop_front();
            total_cnt++;
            if ({inst_data_ok, data_data_ok} !== {~exp_own, exp_own})
                $display("FAIL prio_resp_owner: got %b want %b",
                         {inst_data_ok, data_data_ok}, {~exp_own, exp_own});
            else pass_cnt++;
            total_cnt++;
            if ((exp_own ? data_rdata : inst_rdata) !== 32'h5a00_0000 + k)
                $display("FAIL prio_rdata: got %h want %h",
                         exp_own ? data_rdata : inst_rdata, 32'h5a00_0000 + k);
            else pass_cnt++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_lock();
        inst_req  = 1'b1;
        inst_addr = 32'hbfc0_0010;
        #1;
        total_cnt++;
        if ({mem_req, inst_addr_ok, mem_addr} !== {1'b1, 1'b0, 32'hbfc0_0010})
            $display("FAIL lock_present: got %b %b %h", mem_req, inst_addr_ok, mem_addr);
        else pass_cnt++;
        next_cycle();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'h2;
        data_wstrb = 4'hf;
        data_addr  = 32'h0000_2000;
        data_wdata = 32'h0000_1234;
        for (int unsigned c = 0; c < 2; c++) begin
            #1;
            total_cnt++;
            if ({mem_addr, mem_wr, data_addr_ok} !== {32'hbfc0_0010, 1'b0, 1'b0})
                $display("FAIL lock_hold: got %h %b %b", mem_addr, mem_wr, data_addr_ok);
            else pass_cnt++;
            next_cycle();
        end
        mem_addr_ok = 1'b1;
        #1;
        total_cnt++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10)
            $display("FAIL lock_inst_first: got %b want 10", {inst_addr_ok, data_addr_ok});
        else pass_cnt++;
        exp_q.push_back(1'b0);
        next_cycle();
        inst_req = 1'b0;
        #1;
        total_cnt++;
        if ({data_addr_ok, mem_addr} !== {1'b1, 32'h0000_2000})
            $display("FAIL lock_data_after: got %b %h", data_addr_ok, mem_addr);
        else pass_cnt++;
        exp_q.push_back(1'b1);
        next_cycle();
        idle();
        for (int unsigned k = 0; k < 2; k++) begin
            mem_data_ok = 1'b1;
            #1;
            exp_own = exp_q.pop_front();
            total_cnt++;
            if ({inst_data_ok, data_data_ok} !== {~exp_own, exp_own})
                $display("FAIL lock_resp_owner: got %b want %b",
                         {inst_data_ok, data_data_ok}, {~exp_own, exp_own});
            else pass_cnt++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_in_order();
        for (int unsigned k = 0; k < 4; k++) begin
            inst_req    = (k % 2 == 0);
            data_req    = (k % 2 == 1);
            inst_addr   = 32'hbfc0_0000 + 4 * k;
            data_addr   = 32'h0000_1000 + 4 * k;
            mem_addr_ok = 1'b1;
            #1;
            total_cnt++;
            if ({inst_addr_ok, data_addr_ok} !== ((k % 2 == 1) ? 2'b01 : 2'b10))
                $display("FAIL order_accept[%0d]: got %b", k, {inst_addr_ok, data_addr_ok});
            else pass_cnt++;
            total_cnt++;
            if (mem_addr !== ((k % 2 == 1) ? 32'h0000_1000 + 4 * k : 32'hbfc0_0000 + 4 * k))
                $display("FAIL order_addr[%0d]: got %h", k, mem_addr);
            else pass_cnt++;
            exp_q.push_back(k % 2 == 1);
            next_cycle();
        end
        idle();
        for (int unsigned k = 0; k < 4; k++) begin
            mem_data_ok = 1'b1;
            mem_rdata   = 32'hc0de_0000 + k;
            #1;
            exp_own = exp_q.pop_front();
            total_cnt++;
            if ({inst_data_ok, data_data_ok} !== {~exp_own, exp_own})
                $display("FAIL order_resp_owner[%0d]: got %b want %b",
                         k, {inst_data_ok, data_data_ok}, {~exp_own, exp_own});
            else pass_cnt++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_full();
        issue_alternating(4);
        inst_req    = 1'b1;
        inst_addr   = 32'hbfc0_0100;
        mem_addr_ok = 1'b1;
        #1;
        total_cnt++;
        if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b000)
            $display("FAIL full_block: got %b want 000", {mem_req, inst_addr_ok, data_addr_ok});
        else pass_cnt++;
        next_cycle();
        mem_data_ok = 1'b1;
        #1;
        exp_own = exp_q.pop_front();
        total_cnt++;
        if ({mem_req, inst_data_ok, data_data_ok} !== {1'b0, ~exp_own, exp_own})
            $display("FAIL full_pop: got %b", {mem_req, inst_data_ok, data_data_ok});
        else pass_cnt++;
        next_cycle();
        #1;
        exp_own = exp_q.pop_front();
        total_cnt++;
        if ({inst_addr_ok, inst_data_ok, data_data_ok} !== {1'b1, ~exp_own, exp_own})
            $display("FAIL full_push_pop: got %b", {inst_addr_ok, inst_data_ok, data_data_ok});
        else pass_cnt++;
        exp_q.push_back(1'b0);
        next_cycle();
        mem_data_ok = 1'b0;
        #1;
        total_cnt++;
        if (inst_addr_ok !== 1'b1) $display("FAIL full_refill: got %b want 1", inst_addr_ok);
        else pass_cnt++;
        exp_q.push_back(1'b0);
        next_cycle();
        #1;
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL full_again: got %b want 0", mem_req);
        else pass_cnt++;
        idle();
        next_cycle();
        for (int unsigned k = 0; k < 4; k++) begin
            mem_data_ok = 1'b1;
            #1;
            exp_own = exp_q.pop_front();
            total_cnt++;
            if ({inst_data_ok, data_data_ok} !== {~exp_own, exp_own})
                $display("FAIL full_drain[%0d]: got %b want %b",
                         k, {inst_data_ok, data_data_ok}, {~exp_own, exp_own});
            else pass_cnt++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_spurious();
        mem_data_ok = 1'b1;
        for (int unsigned c = 0; c < 2; c++) begin
            #1;
            total_cnt++;
            if ({inst_data_ok, data_data_ok} !== 2'b00)
                $display("FAIL spurious_data_ok: got %b want 00", {inst_data_ok, data_data_ok});
            else pass_cnt++;
            next_cycle();
        end
        idle();
        issue_alternating(3);
        inst_req    = 1'b1;
        inst_addr   = 32'hbfc0_0200;
        mem_addr_ok = 1'b1;
        #1;
        total_cnt++;
        if (inst_addr_ok !== 1'b1) $display("FAIL spurious_fourth: got %b want 1", inst_addr_ok);
        else pass_cnt++;
        exp_q.push_back(1'b0);
        next_cycle();
        #1;
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL spurious_full: got %b want 0", mem_req);
        else pass_cnt++;
        idle();
        next_cycle();
        for (int unsigned k = 0; k < 4; k++) begin
            mem_data_ok = 1'b1;
            #1;
            exp_own = exp_q.pop_front();
            total_cnt++;
            if ({inst_data_ok, data_data_ok} !== {~exp_own, exp_own})
                $display("FAIL spurious_drain[%0d]: got %b want %b",
                         k, {inst_data_ok, data_data_ok}, {~exp_own, exp_own});
            else pass_cnt++;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        issue_alternating(3);
        inst_req    = 1'b1;
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        total_cnt++;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b00000)
            $display("FAIL midreset_outputs: got %b want 00000",
                     {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        else pass_cnt++;
        exp_q.delete();
        idle();
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        mem_data_ok = 1'b1;
        #1;
        total_cnt++;
        if ({inst_data_ok, data_data_ok} !== 2'b00)
            $display("FAIL midreset_empty: got %b want 00", {inst_data_ok, data_data_ok});
        else pass_cnt++;
        idle();
        next_cycle();
        data_req    = 1'b1;
        data_addr   = 32'h0000_3000;
        mem_addr_ok = 1'b1;
        #1;
        total_cnt++;
        if (data_addr_ok !== 1'b1) $display("FAIL midreset_accept: got %b want 1", data_addr_ok);
        else pass_cnt++;
        exp_q.push_back(1'b1);
        next_cycle();
        idle();
        mem_data_ok = 1'b1;
        #1;
        exp_own = exp_q.pop_front();
        total_cnt++;
        if ({inst_data_ok, data_data_ok} !== {~exp_own, exp_own})
            $display("FAIL midreset_resp: got %b want %b",
                     {inst_data_ok, data_data_ok}, {~exp_own, exp_own});
        else pass_cnt++;
        next_cycle();
        idle();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_lock();
        test_in_order();
        test_full();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
